// File: rtl/receiver.sv
// receiver: UART RX with 16x oversampling, FWFT byte FIFO, error flags and 10 ms break config request (optional RX_ERROR_FIFO_EN)
module receiver #(
  parameter int RX_FIFO_DEPTH = 64,
  parameter int SYSTEM_CLOCK_FREQ = 100_000_000
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       ov_baud_rt_i,
  input  logic       rx_i,
  input  logic [1:0] data_width_i,
  input  logic [1:0] parity_mode_i,
  input  logic [1:0] stop_bits_number_i,
  input  logic       rx_fifo_read_i,
  input  logic       err_clear_i,
  output logic [7:0] rx_data_o,
  output logic       rx_done_o,
  output logic       rx_fifo_empty_o,
  output logic       rx_fifo_full_o,
  output logic       parity_err_o,
  output logic       frame_err_o,
  output logic       overrun_err_o,
  output logic       config_req_slv_o
);
  localparam int COUNT_10MS = SYSTEM_CLOCK_FREQ / 100;
  localparam int CW = $clog2(COUNT_10MS + 1);
  localparam int AW = $clog2(RX_FIFO_DEPTH);
`ifdef RX_ERROR_FIFO_EN
  localparam int EW = 10;
`else
  localparam int EW = 8;
`endif
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, CFG_REQ} state_t;
  state_t state, nxt;
  logic rx_m, rx_s, rx_s_d;
  logic [3:0] br;
  logic [2:0] bit_cnt;
  logic [7:0] sr, data;
  logic pe_p, fe_p, stop_cnt;
  logic [CW-1:0] low_cnt;
  logic [EW-1:0] mem [RX_FIFO_DEPTH];
  logic [EW-1:0] head, entry;
  logic [AW:0] wp, rp;
  logic samp, mid, cfg_hit, two_stop, final_stop, rd, push, ovr_set;
  assign samp = ov_baud_rt_i && br == 4'd15;
  assign mid = ov_baud_rt_i && br == 4'd7;
  assign cfg_hit = low_cnt == CW'(COUNT_10MS) && state != CFG_REQ;
  assign two_stop = stop_bits_number_i == 2'b01;
  // the last stop sample ends the frame, unless a break has just taken over
  assign final_stop = state == STOP && samp && (!two_stop || stop_cnt) && !cfg_hit;
  assign data = sr >> (2'd3 - data_width_i);
  assign rx_fifo_empty_o = wp == rp;
  assign rx_fifo_full_o = wp[AW] != rp[AW] && wp[AW-1:0] == rp[AW-1:0];
  assign rd = rx_fifo_read_i && !rx_fifo_empty_o;
  assign push = final_stop && (!rx_fifo_full_o || rd);
  assign ovr_set = final_stop && rx_fifo_full_o && !rd;
  assign rx_done_o = push;
  assign head = mem[rp[AW-1:0]];
  assign rx_data_o = rx_fifo_empty_o ? 8'd0 : head[7:0];
  assign config_req_slv_o = state == CFG_REQ && rx_s;
`ifdef RX_ERROR_FIFO_EN
  assign entry = {fe_p | ~rx_s, pe_p, data};
  assign parity_err_o = !rx_fifo_empty_o && head[8];
  assign frame_err_o = !rx_fifo_empty_o && head[9];
`else
  assign entry = data;
  always_ff @(posedge clk_i)
    if (rst_i) begin
      parity_err_o <= 1'b0;
      frame_err_o <= 1'b0;
    end else begin
      parity_err_o <= (final_stop && pe_p) || (parity_err_o && !err_clear_i);
      frame_err_o <= (final_stop && (fe_p || !rx_s)) || (frame_err_o && !err_clear_i);
    end
`endif
  always_comb begin
    nxt = state;
    case (state)
      IDLE:    if (rx_s_d && !rx_s) nxt = START;
      START:   if (mid) nxt = rx_s ? IDLE : DATA;
      DATA:    if (samp && bit_cnt == 3'd4 + 3'(data_width_i)) nxt = parity_mode_i[1] ? STOP : PARITY;
      PARITY:  if (samp) nxt = STOP;
      STOP:    if (final_stop) nxt = IDLE;
      CFG_REQ: if (rx_s) nxt = IDLE;
      default: nxt = IDLE;
    endcase
    if (cfg_hit) nxt = CFG_REQ;
  end
  always_ff @(posedge clk_i)
    if (rst_i) begin
      state <= IDLE;
      {rx_m, rx_s, rx_s_d} <= 3'b111;
      br <= 4'd0;
      bit_cnt <= 3'd0;
      sr <= 8'd0;
      pe_p <= 1'b0;
      fe_p <= 1'b0;
      stop_cnt <= 1'b0;
      low_cnt <= '0;
      wp <= '0;
      rp <= '0;
      overrun_err_o <= 1'b0;
    end else begin
      state <= nxt;
      {rx_m, rx_s, rx_s_d} <= {rx_i, rx_m, rx_s};
      br <= (state == IDLE || (state == START && mid)) ? 4'd0 : br + 4'(ov_baud_rt_i);
      bit_cnt <= state != DATA ? 3'd0 : bit_cnt + 3'(samp);
      if (state == DATA && samp) sr <= {rx_s, sr[7:1]};
      if (state == START) pe_p <= 1'b0;
      else if (state == PARITY && samp) pe_p <= (^data ^ rx_s) != parity_mode_i[0];
      if (state == START) fe_p <= 1'b0;
      else if (state == STOP && samp && !rx_s) fe_p <= 1'b1;
      stop_cnt <= state == STOP && (stop_cnt || samp);
      low_cnt <= rx_s ? '0 : low_cnt + CW'(low_cnt != CW'(COUNT_10MS));
      if (push) wp <= wp + 1'b1;
      if (rd) rp <= rp + 1'b1;
      overrun_err_o <= ovr_set || (overrun_err_o && !err_clear_i);
    end
  always_ff @(posedge clk_i)
    if (push) mem[wp[AW-1:0]] <= entry;
endmodule

// File: tb/tb_receiver.sv
// tb_receiver: directed self-checking bench for receiver
module tb_receiver;
  localparam int BIT = 64;
  logic clk = 0, rst = 1, tick = 0, tick_en = 1, rx = 1, rd = 0, clr = 0;
  logic [1:0] dw = 2'b11, pm = 2'b10, sb = 2'b00;
  logic [7:0] rx_data;
  logic done, empty, full, pe, fe, ov, cfg;
  int tests = 0, fails = 0, done_cnt = 0, cfg_cnt = 0, tcnt = 0, base;
  logic done_d = 0;
  logic [7:0] after_done = 0;

  receiver #(.RX_FIFO_DEPTH(64), .SYSTEM_CLOCK_FREQ(1_000_000)) dut (
    .clk_i(clk), .rst_i(rst), .ov_baud_rt_i(tick), .rx_i(rx),
    .data_width_i(dw), .parity_mode_i(pm), .stop_bits_number_i(sb),
    .rx_fifo_read_i(rd), .err_clear_i(clr), .rx_data_o(rx_data),
    .rx_done_o(done), .rx_fifo_empty_o(empty), .rx_fifo_full_o(full),
    .parity_err_o(pe), .frame_err_o(fe), .overrun_err_o(ov),
    .config_req_slv_o(cfg));

  always #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    #1;
    tcnt = (tcnt + 1) % 4;
    tick = tick_en && tcnt == 0;
  end

  always @(negedge clk) begin
    if (done_d) after_done = rx_data;
    done_d = done;
    if (done) done_cnt++;
    if (cfg) cfg_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic bit_out(input logic v);
    rx = v;
    repeat (BIT) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] d, input int n, input bit has_par, input bit par,
                            input int nstop, input bit stop_val);
    bit_out(1'b0);
    for (int i = 0; i < n; i++) bit_out(d[i]);
    if (has_par) bit_out(par);
    for (int i = 0; i < nstop; i++) bit_out(stop_val);
    rx = 1;
    repeat (32) @(posedge clk);
    #1;
  endtask

  task automatic pulse_rd();
    @(posedge clk); #1 rd = 1;
    @(posedge clk); #1 rd = 0;
  endtask

  task automatic pulse_clr();
    @(posedge clk); #1 clr = 1;
    @(posedge clk); #1 clr = 0;
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1 rst = 0;
    @(negedge clk);
    check("rst_data", 32'(rx_data), 32'h0);
    check("rst_empty", 32'(empty), 32'h1);
    check("rst_full", 32'(full), 32'h0);
    check("rst_flags", 32'({done, pe, fe, ov, cfg}), 32'h0);
    @(posedge clk); #1;

    send_frame(8'hA5, 8, 0, 0, 1, 1);
    @(negedge clk);
    check("8n1_done_cnt", 32'(done_cnt), 32'd1);
    check("8n1_after_done", 32'(after_done), 32'hA5);
    check("8n1_data", 32'(rx_data), 32'hA5);
    check("8n1_empty", 32'(empty), 32'h0);
    check("8n1_flags", 32'({pe, fe, ov}), 32'h0);
    pulse_rd();
    @(negedge clk);
    check("8n1_pop_empty", 32'(empty), 32'h1);

    dw = 2'b10; pm = 2'b00; sb = 2'b01;
    @(posedge clk); #1;
    send_frame(8'h41, 7, 1, 0, 2, 1);
    @(negedge clk);
    check("7e2_data", 32'(rx_data), 32'h41);
    check("7e2_pe_ok", 32'(pe), 32'h0);
    pulse_rd();
    send_frame(8'h41, 7, 1, 1, 2, 1);
    @(negedge clk);
    check("7e2_bad_data", 32'(rx_data), 32'h41);
    check("7e2_pe_set", 32'(pe), 32'h1);
    check("7e2_fe_clear", 32'(fe), 32'h0);
    pulse_rd();
    @(negedge clk);
    check("7e2_pe_sticky", 32'(pe), 32'h1);
    pulse_clr();
    @(negedge clk);
    check("7e2_pe_cleared", 32'(pe), 32'h0);

    dw = 2'b00; pm = 2'b10; sb = 2'b00;
    @(posedge clk); #1;
    send_frame(8'h1F, 5, 0, 0, 1, 0);
    @(negedge clk);
    check("5n1_data", 32'(rx_data), 32'h1F);
    check("5n1_fe", 32'(fe), 32'h1);
    check("5n1_pe", 32'(pe), 32'h0);
    pulse_rd();
    pulse_clr();

    dw = 2'b11;
    base = done_cnt;
    @(posedge clk); #1 rx = 0;
    repeat (19) @(posedge clk);
    #1 rx = 1;
    repeat (300) @(posedge clk);
    @(negedge clk);
    check("glitch_no_push", 32'(done_cnt - base), 32'd0);
    check("glitch_empty", 32'(empty), 32'h1);
    check("glitch_flags", 32'({pe, fe, ov}), 32'h0);
    @(posedge clk); #1;

    base = done_cnt;
    for (int i = 0; i < 64; i++) send_frame(8'(i), 8, 0, 0, 1, 1);
    @(negedge clk);
    check("fill_pushes", 32'(done_cnt - base), 32'd64);
    check("fill_full", 32'(full), 32'h1);
    check("fill_no_ov", 32'(ov), 32'h0);
    @(posedge clk); #1;
    send_frame(8'hFF, 8, 0, 0, 1, 1);
    @(negedge clk);
    check("ovr_no_push", 32'(done_cnt - base), 32'd64);
    check("ovr_flag", 32'(ov), 32'h1);
    check("ovr_full", 32'(full), 32'h1);
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      check($sformatf("drain_%0d", i), 32'(rx_data), 32'(i));
      pulse_rd();
    end
    @(negedge clk);
    check("drain_empty", 32'(empty), 32'h1);
    check("drain_data_zero", 32'(rx_data), 32'h0);
    pulse_clr();
    @(negedge clk);
    check("ovr_cleared", 32'(ov), 32'h0);

    tick_en = 0;
    base = done_cnt;
    @(posedge clk); #1 rx = 0;
    repeat (10500) @(posedge clk);
    #1;
    check("cfg_not_early", 32'(cfg_cnt), 32'd0);
    rx = 1;
    repeat (100) @(posedge clk);
    @(negedge clk);
    check("cfg_one_pulse", 32'(cfg_cnt), 32'd1);
    check("cfg_no_push", 32'(done_cnt - base), 32'd0);
    check("cfg_empty", 32'(empty), 32'h1);
    check("cfg_fe", 32'(fe), 32'h0);
    tick_en = 1;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
